key_conditioner: RTL and testbench

Front-end input stage for the countdown timer: it turns the four raw, active-low, bouncing KEY push-buttons into clean, synchronous control signals. For each key it provides a debounced level, single-cycle press and release pulses, an optional auto-repeat pulse, and a toggle bit. The timer control FSM uses these outputs for set, start/stop, and reset in place of raw KEY edges.

---
 rtl/key_conditioner_if.sv | 23 ++
 rtl/key_conditioner.sv | 128 ++++++++++++
 tb/tb_key_conditioner.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/key_conditioner_if.sv
// Signal bundle between the raw KEY pins / timer control and the key conditioner.
// The conditioner takes the slave view. The timer side (or a bench) takes the master view.
interface key_conditioner_if #(
  parameter int unsigned N_KEYS = 4
);
  logic [N_KEYS-1:0] KEY;
  logic [N_KEYS-1:0] toggle_clr;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] key_press;
  logic [N_KEYS-1:0] key_release;
  logic [N_KEYS-1:0] key_repeat;
  logic [N_KEYS-1:0] key_toggle;

  modport master (
    output KEY, toggle_clr,
    input  key_level, key_press, key_release, key_repeat, key_toggle
  );

  modport slave (
    input  KEY, toggle_clr,
    output key_level, key_press, key_release, key_repeat, key_toggle
  );
endinterface

// File: rtl/key_conditioner.sv
// Per-key synchronizer, debouncer, press/release pulses, auto-repeat and toggle for
// active-low push-buttons. Every key has its own independent, identical channel.
module key_conditioner #(
  parameter int unsigned       N_KEYS          = 4,
  parameter int unsigned       DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned       HOLD_CYCLES     = 25000000,
  parameter int unsigned       REPEAT_CYCLES   = 10000000,
  parameter logic [N_KEYS-1:0] REPEAT_MASK     = '0,
  parameter int unsigned       CNT_W           = 26
) (
  input logic              CLOCK_50,
  input logic              reset,
  key_conditioner_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StHold, StRepeat} rp_state_e;

  logic [N_KEYS-1:0] w_level, w_press, w_release, w_repeat, w_toggle;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    logic             r_s1, r_s2, r_level, r_press, r_release, r_toggle, r_repeat;
    logic [CNT_W-1:0] r_db_cnt, r_rp_cnt, w_rp_cnt_d;
    logic             w_accept, w_rise, w_fall, w_repeat_d;
    rp_state_e        r_state, w_state_d;

    assign w_accept = (r_s2 != r_level) && (r_db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
    assign w_rise   = w_accept && r_s2;
    assign w_fall   = w_accept && !r_s2;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
        r_s1      <= 1'b0;
        r_s2      <= 1'b0;
        r_level   <= 1'b0;
        r_db_cnt  <= '0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
        r_toggle  <= 1'b0;
      end else begin
        r_s1 <= ~bus.KEY[i];
        r_s2 <= r_s1;
        // Any return to the current level restarts the stability count.
        if (r_s2 == r_level) begin
          r_db_cnt <= '0;
        end else if (w_accept) begin
          r_level  <= r_s2;
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + CNT_W'(1);
        end
        r_press   <= w_rise;
        r_release <= w_fall;
        if (bus.toggle_clr[i]) begin
          r_toggle <= 1'b0;
        end else if (w_rise) begin
          r_toggle <= ~r_toggle;
        end
      end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
        r_state  <= StIdle;
        r_rp_cnt <= '0;
        r_repeat <= 1'b0;
      end else begin
        r_state  <= w_state_d;
        r_rp_cnt <= w_rp_cnt_d;
        r_repeat <= w_repeat_d;
      end
    end

    // Masked-off keys never leave StIdle, so their repeat output stays 0.
    always_comb begin
      w_state_d  = r_state;
      w_rp_cnt_d = r_rp_cnt;
      w_repeat_d = 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_rise && REPEAT_MASK[i]) begin
            w_state_d  = StHold;
            w_rp_cnt_d = '0;
          end
        end
        StHold: begin
          if (w_fall) begin
            w_state_d  = StIdle;
            w_rp_cnt_d = '0;
          end else if (r_rp_cnt == CNT_W'(HOLD_CYCLES - 1)) begin
            w_state_d  = StRepeat;
            w_rp_cnt_d = '0;
            w_repeat_d = 1'b1;
          end else begin
            w_rp_cnt_d = r_rp_cnt + CNT_W'(1);
          end
        end
        StRepeat: begin
          if (w_fall) begin
            w_state_d  = StIdle;
            w_rp_cnt_d = '0;
          end else if (r_rp_cnt == CNT_W'(REPEAT_CYCLES - 1)) begin
            w_rp_cnt_d = '0;
            w_repeat_d = 1'b1;
          end else begin
            w_rp_cnt_d = r_rp_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_d  = StIdle;
          w_rp_cnt_d = '0;
        end
      endcase
    end

    assign w_level[i]   = r_level;
    assign w_press[i]   = r_press;
    assign w_release[i] = r_release;
    assign w_repeat[i]  = r_repeat;
    assign w_toggle[i]  = r_toggle;
  end

  assign bus.key_level   = w_level;
  assign bus.key_press   = w_press;
  assign bus.key_release = w_release;
  assign bus.key_repeat  = w_repeat;
  assign bus.key_toggle  = w_toggle;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner: pulses are checked against a cycle-stamped scoreboard,
// levels and toggles are checked at fixed points in the sequence.
module tb_key_conditioner;
  localparam int unsigned NK = 4;

  typedef struct {
    int        cyc;
    logic [3:0] p;
    logic [3:0] r;
    logic [3:0] rp;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  ev_t  sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  key_conditioner_if #(.N_KEYS(NK)) bus ();

  key_conditioner #(
    .N_KEYS(NK),
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES(8),
    .REPEAT_CYCLES(3),
    .REPEAT_MASK(4'b0010),
    .CNT_W(8)
  ) dut (
    .CLOCK_50(clk),
    .reset(rst),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s at cycle %0d: observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Events at the same cycle merge; pushes must arrive in non-decreasing cycle order.
  function automatic void push(input int c, input logic [3:0] p, input logic [3:0] r,
                               input logic [3:0] rp);
    ev_t e;
    if (sb.size() > 0 && sb[sb.size()-1].cyc == c) begin
      sb[sb.size()-1].p  |= p;
      sb[sb.size()-1].r  |= r;
      sb[sb.size()-1].rp |= rp;
    end else begin
      e.cyc = c;
      e.p   = p;
      e.r   = r;
      e.rp  = rp;
      sb.push_back(e);
    end
  endfunction

  // Pulse monitor: every cycle either matches the scoreboard head or must be pulse-free.
  always @(negedge clk) begin
    ev_t e;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      chk("sb_missed_cycle", cyc, e.cyc);
    end
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      chk("key_press", bus.key_press, e.p);
      chk("key_release", bus.key_release, e.r);
      chk("key_repeat", bus.key_repeat, e.rp);
    end else if (|bus.key_press || |bus.key_release || |bus.key_repeat) begin
      chk("unexpected_pulse", {bus.key_press, bus.key_release, bus.key_repeat}, 12'h000);
    end
  end

  initial begin
    int c;
    int p;
    int r;
    rst = 1'b1;
    bus.KEY = '1;
    bus.toggle_clr = '0;
    tick(3);
    chk("rst_level", bus.key_level, 4'h0);
    chk("rst_press", bus.key_press, 4'h0);
    chk("rst_release", bus.key_release, 4'h0);
    chk("rst_repeat", bus.key_repeat, 4'h0);
    chk("rst_toggle", bus.key_toggle, 4'h0);
    rst = 1'b0;
    tick(3);

    // Clean press of KEY[2]
    c = cyc;
    bus.KEY[2] = 1'b0;
    push(c + 6, 4'b0100, 4'b0000, 4'b0000);
    tick(5);
    chk("press2_level_before", bus.key_level, 4'h0);
    tick(1);
    chk("press2_level", bus.key_level, 4'b0100);
    chk("press2_toggle", bus.key_toggle, 4'b0100);
    tick(14);
    bus.KEY[2] = 1'b1;
    push(cyc + 6, 4'b0000, 4'b0100, 4'b0000);
    tick(10);
    chk("rel2_level", bus.key_level, 4'h0);
    chk("rel2_toggle_held", bus.key_toggle, 4'b0100);

    // Second press toggles back to 0
    bus.KEY[2] = 1'b0;
    push(cyc + 6, 4'b0100, 4'b0000, 4'b0000);
    tick(6);
    chk("press2b_toggle", bus.key_toggle, 4'b0000);
    bus.KEY[2] = 1'b1;
    push(cyc + 6, 4'b0000, 4'b0100, 4'b0000);
    tick(10);

    // Third press coincides with toggle_clr: clear wins
    bus.KEY[2] = 1'b0;
    push(cyc + 6, 4'b0100, 4'b0000, 4'b0000);
    tick(5);
    bus.toggle_clr[2] = 1'b1;
    tick(1);
    bus.toggle_clr[2] = 1'b0;
    chk("toggle_clr_wins", bus.key_toggle, 4'b0000);
    chk("press2c_level", bus.key_level, 4'b0100);
    bus.KEY[2] = 1'b1;
    push(cyc + 6, 4'b0000, 4'b0100, 4'b0000);
    tick(10);

    // Bouncing press of KEY[1], then hold for auto-repeat
    bus.KEY[1] = 1'b0;
    tick(3);
    bus.KEY[1] = 1'b1;
    tick(1);
    bus.KEY[1] = 1'b0;
    tick(3);
    bus.KEY[1] = 1'b1;
    tick(1);
    bus.KEY[1] = 1'b0;
    p = cyc + 6;
    push(p, 4'b0010, 4'b0000, 4'b0000);
    for (int k = 0; k < 8; k++) push(p + 8 + 3 * k, 4'b0000, 4'b0000, 4'b0010);
    tick(5);
    chk("bounce_level_low", bus.key_level, 4'h0);
    tick(1);
    chk("bounce_level_high", bus.key_level, 4'b0010);
    tick(20);
    chk("hold1_level", bus.key_level, 4'b0010);
    tick(6);
    // Release lands on a cycle where a repeat would otherwise fire
    bus.KEY[1] = 1'b1;
    push(p + 32, 4'b0000, 4'b0010, 4'b0000);
    tick(6);
    chk("rel1_level", bus.key_level, 4'h0);
    tick(10);

    // Simultaneous KEY[0] and KEY[3] (neither auto-repeats)
    c = cyc;
    bus.KEY[0] = 1'b0;
    bus.KEY[3] = 1'b0;
    push(c + 6, 4'b1001, 4'b0000, 4'b0000);
    tick(6);
    chk("simul_level", bus.key_level, 4'b1001);
    chk("simul_toggle", bus.key_toggle, 4'b1011);
    tick(24);
    bus.KEY[0] = 1'b1;
    bus.KEY[3] = 1'b1;
    push(cyc + 6, 4'b0000, 4'b1001, 4'b0000);
    tick(10);

    // Reset while KEY[1] is held in the repeat phase
    c = cyc;
    bus.KEY[1] = 1'b0;
    p = c + 6;
    push(p, 4'b0010, 4'b0000, 4'b0000);
    push(p + 8, 4'b0000, 4'b0000, 4'b0010);
    push(p + 11, 4'b0000, 4'b0000, 4'b0010);
    tick(17);
    chk("pre_reset_toggle", bus.key_toggle, 4'b1001);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_level", bus.key_level, 4'h0);
    chk("async_rst_repeat", bus.key_repeat, 4'h0);
    chk("async_rst_toggle", bus.key_toggle, 4'h0);
    tick(3);
    rst = 1'b0;
    r = cyc;
    push(r + 6, 4'b0010, 4'b0000, 4'b0000);
    tick(5);
    chk("post_rst_level_before", bus.key_level, 4'h0);
    tick(1);
    chk("post_rst_level", bus.key_level, 4'b0010);
    chk("post_rst_toggle", bus.key_toggle, 4'b0010);
    bus.KEY[1] = 1'b1;
    push(cyc + 6, 4'b0000, 4'b0010, 4'b0000);
    tick(14);

    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
